// File: rtl/ms_jk_pkg.sv
// Shared types for the master-slave JK counter: operating modes and per-bit JK codes.
package ms_jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE  = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    LOAD     = 2'b11
  } jk_mode_e;

  // Per-bit {J,K} codes.
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/ms_jk_next_state.sv
// Combinational next-state and wrap-pending logic for ms_jk_counter.
// Define MS_JK_SAT_EN to make up/down counting saturate instead of wrapping.
module ms_jk_next_state #(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  ms_jk_pkg::jk_mode_e mode,
  input  logic [WIDTH-1:0]    q,
  input  logic [WIDTH-1:0]    j,
  input  logic [WIDTH-1:0]    k,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    next_q,
  output logic                wrap_pend
);
  import ms_jk_pkg::*;

  // One extra bit so MOD itself is representable when MOD == 2**WIDTH.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] ld_ext;
  logic [WIDTH:0] q_inc;
  logic [WIDTH:0] q_dec;

  assign q_ext  = {1'b0, q};
  assign ld_ext = {1'b0, load_val};
  assign q_inc  = q_ext + 1'b1;
  assign q_dec  = q_ext - 1'b1;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_q    = q;
    wrap_pend = 1'b0;
    case (mode)
      JK_MODE: begin
        for (int i = 0; i < WIDTH; i++) begin
          case ({j[i], k[i]})
            HOLD:    next_q[i] = q[i];
            RESET:   next_q[i] = 1'b0;
            SET:     next_q[i] = 1'b1;
            default: next_q[i] = ~q[i];
          endcase
        end
      end
      CNT_UP: begin
        if (q_ext >= MAX_W) begin
`ifdef MS_JK_SAT_EN
          next_q = MAX_W[WIDTH-1:0];
`else
          next_q    = '0;
          wrap_pend = 1'b1;
`endif
        end else begin
          next_q = q_inc[WIDTH-1:0];
        end
      end
      CNT_DOWN: begin
        if (q_ext == '0) begin
`ifdef MS_JK_SAT_EN
          next_q = '0;
`else
          next_q    = MAX_W[WIDTH-1:0];
          wrap_pend = 1'b1;
`endif
        end else if (q_ext >= MOD_W) begin
          next_q = MAX_W[WIDTH-1:0];
        end else begin
          next_q = q_dec[WIDTH-1:0];
        end
      end
      default: begin
        next_q = (ld_ext >= MOD_W) ? MAX_W[WIDTH-1:0] : load_val;
      end
    endcase
  end

endmodule

// File: rtl/ms_jk_counter.sv
// Master-slave JK register/counter: master captures on posedge, slave drives Q on negedge.
// Optional MS_JK_SAT_EN selects saturating up/down counting (wrap never asserts).
module ms_jk_counter #(
  parameter int WIDTH   = 8,
  parameter int MOD     = 2**WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             tc,
  output logic             wrap
);
  import ms_jk_pkg::*;

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MOD) - 1'b1;

  jk_mode_e         mode_e;
  logic [WIDTH-1:0] next_q;
  logic             wrap_pend;
  logic [WIDTH-1:0] master;
  logic             master_wrap;

  assign mode_e = jk_mode_e'(mode);

  ms_jk_next_state #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .mode      (mode_e),
    .q         (Q),
    .j         (J),
    .k         (K),
    .load_val  (load_val),
    .next_q    (next_q),
    .wrap_pend (wrap_pend)
  );

  // Master: edge-triggered capture, so input activity after posedge is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      master      <= RST_Q;
      master_wrap <= 1'b0;
    end else if (en) begin
      master      <= next_q;
      master_wrap <= wrap_pend;
    end else begin
      master_wrap <= 1'b0;
    end
  end

  // Slave: reset also clears the master, so a pre-reset decision never reaches Q.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      Q    <= master;
      wrap <= master_wrap;
    end
  end

  assign Qn = ~Q;
  assign tc = ((mode_e == CNT_UP)   && ({1'b0, Q} == MAX_W)) ||
              ((mode_e == CNT_DOWN) && (Q == '0));

endmodule

// File: tb/tb_ms_jk_counter.sv
// Scoreboard bench for ms_jk_counter (WIDTH=4, MOD=10); saturating checks run when MS_JK_SAT_EN is defined.
module tb_ms_jk_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

`ifdef MS_JK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] J, K, load_val;
  logic [W-1:0] Q, Qn;
  logic         tc, wrap;

  typedef struct {
    logic [W-1:0] q;
    logic         wrap;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mq;
  int           total = 0;
  int           bad   = 0;

  ms_jk_counter #(.WIDTH(W), .MOD(MOD), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .J        (J),
    .K        (K),
    .load_val (load_val),
    .Q        (Q),
    .Qn       (Qn),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Reference behaviour written from the functional description, integer arithmetic.
  function automatic exp_t model(input logic e, input logic [1:0] m, input logic [W-1:0] q,
                                 input logic [W-1:0] j, input logic [W-1:0] k,
                                 input logic [W-1:0] lv);
    exp_t r;
    int   qi;
    qi     = int'(q);
    r.q    = q;
    r.wrap = 1'b0;
    if (e) begin
      case (m)
        2'd0: for (int i = 0; i < W; i++)
                r.q[i] = (j[i] && k[i]) ? ~q[i] : (j[i] ? 1'b1 : (k[i] ? 1'b0 : q[i]));
        2'd1: begin
          if (qi >= MOD - 1) begin
            r.q    = SAT ? W'(MOD - 1) : '0;
            r.wrap = !SAT;
          end else r.q = W'(qi + 1);
        end
        2'd2: begin
          if (qi == 0) begin
            r.q    = SAT ? '0 : W'(MOD - 1);
            r.wrap = !SAT;
          end else if (qi >= MOD) r.q = W'(MOD - 1);
          else r.q = W'(qi - 1);
        end
        default: r.q = (int'(lv) >= MOD) ? W'(MOD - 1) : lv;
      endcase
    end
    return r;
  endfunction

  function automatic logic exp_tc(input logic [1:0] m, input logic [W-1:0] q);
    return ((m == 2'd1) && (int'(q) == MOD - 1)) || ((m == 2'd2) && (q == '0));
  endfunction

  task automatic pop_check(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, Q=%h", name, Q);
      return;
    end
    e = sb.pop_front();
    if (Q !== e.q) begin
      bad++;
      $display("FAIL %s Q: got %h expected %h", name, Q, e.q);
    end
    total++;
    if (Qn !== ~e.q) begin
      bad++;
      $display("FAIL %s Qn: got %h expected %h", name, Qn, ~e.q);
    end
    total++;
    if (wrap !== e.wrap) begin
      bad++;
      $display("FAIL %s wrap: got %b expected %b", name, wrap, e.wrap);
    end
    total++;
    if (tc !== exp_tc(mode, e.q)) begin
      bad++;
      $display("FAIL %s tc: got %b expected %b", name, tc, exp_tc(mode, e.q));
    end
  endtask

  // Inputs are driven just after a negedge; result is checked just after the next negedge.
  task automatic step(input string name, input logic e, input logic [1:0] m,
                      input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] lv);
    exp_t r;
    en = e; mode = m; J = j; K = k; load_val = lv;
    r  = model(e, m, mq, j, k, lv);
    mq = r.q;
    sb.push_back(r);
    @(posedge clk); #1;
    @(negedge clk); #1;
    pop_check(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; J = '0; K = '0; load_val = '0;
    mq = '0;
    repeat (2) @(negedge clk);
    #1;
    sb.push_back('{q: 4'h0, wrap: 1'b0});
    pop_check("reset_jk");
    mode = 2'd2; #1;
    sb.push_back('{q: 4'h0, wrap: 1'b0});
    pop_check("reset_tc_down");
    mode = 2'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    for (int c = 0; c < 12; c++) step("count_up", 1'b1, 2'd1, '0, '0, '0);
  endtask

  task automatic test_down_load();
    step("load0",      1'b1, 2'd3, '0, '0, 4'h0);
    step("down_wrap",  1'b1, 2'd2, '0, '0, '0);
    step("load_clamp", 1'b1, 2'd3, '0, '0, 4'hF);
    step("down_8",     1'b1, 2'd2, '0, '0, '0);
    step("load_high",  1'b1, 2'd3, '0, '0, 4'hC);
    step("down_large", 1'b1, 2'd2, '0, '0, '0);
  endtask

  task automatic test_jk();
    step("load5", 1'b1, 2'd3, '0, '0, 4'b0101);
    step("jk_mix", 1'b1, 2'd0, 4'b0011, 4'b1001, '0);
    total++;
    if (Q !== 4'b0110 || Qn !== 4'b1001) begin
      bad++;
      $display("FAIL jk_literal: got Q=%b Qn=%b expected Q=0110 Qn=1001", Q, Qn);
    end
    step("jk_toggle_all", 1'b1, 2'd0, 4'hF, 4'hF, '0);
    step("jk_over_mod",   1'b1, 2'd0, 4'hF, 4'h0, '0);
  endtask

  task automatic test_enable_and_glitch();
    step("load8", 1'b1, 2'd3, '0, '0, 4'h8);
    for (int c = 0; c < 3; c++) step("en_low", 1'b0, 2'd1, '0, '0, '0);
    step("up_9", 1'b1, 2'd1, '0, '0, '0);
    // Hold decision captured at posedge, then inputs thrash before the negedge.
    en = 1'b1; mode = 2'd0; J = '0; K = '0; load_val = '0;
    sb.push_back(model(1'b1, 2'd0, mq, '0, '0, '0));
    @(posedge clk); #1;
    J = 4'hF; K = 4'h0; mode = 2'd3; load_val = 4'h2;
    #1 J = 4'h0; K = 4'hF;
    @(negedge clk); #1;
    pop_check("mid_cycle_change");
  endtask

  task automatic test_async_reset();
    step("load6", 1'b1, 2'd3, '0, '0, 4'h6);
    step("up_7",  1'b1, 2'd1, '0, '0, '0);
    en = 1'b1; mode = 2'd1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    total++;
    if (Q !== 4'h0) begin
      bad++;
      $display("FAIL async_reset_now: got %h expected 0", Q);
    end
    @(negedge clk); #1;
    mq = '0;
    sb.push_back('{q: 4'h0, wrap: 1'b0});
    pop_check("reset_no_update");
    rst_n = 1'b1;
    step("resume_1", 1'b1, 2'd1, '0, '0, '0);
    step("resume_2", 1'b1, 2'd1, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      logic [1:0]   m;
      logic [W-1:0] a, b;
      m = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      step("random_mix", 1'($urandom_range(0, 1)), m, a, b, a ^ b);
    end
  endtask

`ifdef MS_JK_SAT_EN
  task automatic test_saturate();
    step("sat_load9", 1'b1, 2'd3, '0, '0, 4'h9);
    step("sat_up",    1'b1, 2'd1, '0, '0, '0);
    step("sat_load0", 1'b1, 2'd3, '0, '0, 4'h0);
    step("sat_down",  1'b1, 2'd2, '0, '0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_down_load();
    test_jk();
    test_enable_and_glitch();
    test_async_reset();
    test_back_to_back();
`ifdef MS_JK_SAT_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
